// File: rtl/exp_f32_preclamp_pkg.sv
// Shared types and constants for the fp32 exp() argument pre-clamp stage.
package exp_f32_preclamp_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_OVF    = 2'd1,
    CLS_UDF    = 2'd2,
    CLS_NAN    = 2'd3
  } cls_t;

  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] DEF_HI_LIMIT  = 32'h42B1_7218;  // +88.7228
  localparam logic [31:0] DEF_LO_LIMIT  = 32'hC2CF_F1B5;  // -103.9721

endpackage

// File: rtl/exp_f32_preclamp_lane.sv
// Single-lane classify/clamp of an fp32 exp() argument; purely combinational.
module exp_f32_preclamp_lane
  import exp_f32_preclamp_pkg::*;
#(
  parameter logic [31:0] HI_LIMIT = DEF_HI_LIMIT,
  parameter logic [31:0] LO_LIMIT = DEF_LO_LIMIT
) (
  input  logic [31:0] arg,
  output logic [31:0] result,
  output cls_t        cls
);

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;
  logic [30:0] mag;

  assign sign = arg[31];
  assign expo = arg[30:23];
  assign mant = arg[22:0];
  assign mag  = arg[30:0];

  // Sign-magnitude compares only; infinities fall into the limit checks.
  always_comb begin
    result = arg;
    cls    = CLS_NORMAL;
    if (expo == FP32_EXP_MAX && mant != '0) begin
      cls = CLS_NAN;
    end else if (expo == '0) begin
      result = FP32_POS_ZERO;
    end else if (!sign && mag > HI_LIMIT[30:0]) begin
      cls    = CLS_OVF;
      result = HI_LIMIT;
    end else if (sign && mag > LO_LIMIT[30:0]) begin
      cls    = CLS_UDF;
      result = LO_LIMIT;
    end
  end

endmodule

// File: rtl/exp_f32_preclamp.sv
// Per-lane exp() argument clamp behind a 2-entry AXI4-Stream register slice.
// Optional saturating class statistics: define EXP_F32_PRECLAMP_STATS_EN.
module exp_f32_preclamp
  import exp_f32_preclamp_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter logic [31:0] HI_LIMIT  = DEF_HI_LIMIT,
  parameter logic [31:0] LO_LIMIT  = DEF_LO_LIMIT,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*LANES-1:0]    s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [32*LANES-1:0]    m_data,
  output logic [2*LANES-1:0]     m_class,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   stat_clear,
  output logic [STAT_BITS-1:0]   stat_ovf_count,
  output logic [STAT_BITS-1:0]   stat_udf_count,
  output logic [STAT_BITS-1:0]   stat_nan_count
);

  logic [32*LANES-1:0] clamped;
  logic [2*LANES-1:0]  cls_vec;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cls_t cls;
    exp_f32_preclamp_lane #(
      .HI_LIMIT(HI_LIMIT),
      .LO_LIMIT(LO_LIMIT)
    ) u_lane (
      .arg    (s_data[32*g +: 32]),
      .result (clamped[32*g +: 32]),
      .cls    (cls)
    );
    assign cls_vec[2*g +: 2] = cls;
  end

  logic                skid_valid;
  logic [32*LANES-1:0] skid_data;
  logic [2*LANES-1:0]  skid_class;
  logic                accept;
  logic                drain;
  logic                skid_load;
  logic                skid_valid_next;

  always_comb begin
    accept          = s_valid && s_ready;
    drain           = !m_valid || m_ready;
    skid_load       = accept && !drain;
    skid_valid_next = skid_valid;
    if (skid_load) begin
      skid_valid_next = 1'b1;
    end else if (drain) begin
      skid_valid_next = 1'b0;
    end
  end

  // s_ready is registered off the next skid state so it never depends on m_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_class    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_class <= '0;
      s_ready    <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      s_ready    <= !skid_valid_next;
      if (drain) begin
        if (skid_valid) begin
          m_data  <= skid_data;
          m_class <= skid_class;
          m_valid <= 1'b1;
        end else if (accept) begin
          m_data  <= clamped;
          m_class <= cls_vec;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (skid_load) begin
        skid_data  <= clamped;
        skid_class <= cls_vec;
      end
    end
  end

`ifdef EXP_F32_PRECLAMP_STATS_EN
  localparam int unsigned POP_BITS = $clog2(LANES + 1);

  logic [POP_BITS-1:0] ovf_pop;
  logic [POP_BITS-1:0] udf_pop;
  logic [POP_BITS-1:0] nan_pop;

  always_comb begin
    ovf_pop = '0;
    udf_pop = '0;
    nan_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (cls_t'(cls_vec[2*i +: 2]))
        CLS_OVF: ovf_pop = ovf_pop + POP_BITS'(1);
        CLS_UDF: udf_pop = udf_pop + POP_BITS'(1);
        CLS_NAN: nan_pop = nan_pop + POP_BITS'(1);
        default: ;
      endcase
    end
  end

  function automatic logic [STAT_BITS-1:0] sat_add(input logic [STAT_BITS-1:0] cnt,
                                                   input logic [POP_BITS-1:0]  inc);
    logic [STAT_BITS:0] sum;
    sum = {1'b0, cnt} + (STAT_BITS+1)'(inc);
    return sum[STAT_BITS] ? '1 : sum[STAT_BITS-1:0];
  endfunction

  // Clear takes priority over a same-cycle accept; that beat is not counted.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_ovf_count <= '0;
      stat_udf_count <= '0;
      stat_nan_count <= '0;
    end else if (accept) begin
      stat_ovf_count <= sat_add(stat_ovf_count, ovf_pop);
      stat_udf_count <= sat_add(stat_udf_count, udf_pop);
      stat_nan_count <= sat_add(stat_nan_count, nan_pop);
    end
  end
`else
  logic stat_clear_unused;
  assign stat_clear_unused = stat_clear;
  assign stat_ovf_count    = '0;
  assign stat_udf_count    = '0;
  assign stat_nan_count    = '0;
`endif

endmodule

// File: tb/tb_exp_f32_preclamp.sv
// Scoreboard bench for exp_f32_preclamp (stats checks follow EXP_F32_PRECLAMP_STATS_EN).
module tb_exp_f32_preclamp;

  localparam int          LANES = 4;
  localparam int          SB    = 8;
  localparam logic [31:0] HI    = 32'h42B17218;
  localparam logic [31:0] LO    = 32'hC2CFF1B5;
  localparam logic [31:0] PINF  = 32'h7F800000;
  localparam logic [31:0] SPECIALS [12] = '{
    32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h7FC00000, 32'hFF800001, 32'h00000001, 32'h42B17218,
    32'hC2CFF1B5, 32'h42B17219, 32'hC2CFF1B6, 32'h3F800000
  };

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [127:0]   s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [127:0]   m_data;
  logic [7:0]     m_class;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic           stat_clear = 1'b0;
  logic [SB-1:0]  stat_ovf_count;
  logic [SB-1:0]  stat_udf_count;
  logic [SB-1:0]  stat_nan_count;

  exp_f32_preclamp #(
    .LANES(LANES),
    .STAT_BITS(SB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_data         (m_data),
    .m_class        (m_class),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .stat_clear     (stat_clear),
    .stat_ovf_count (stat_ovf_count),
    .stat_udf_count (stat_udf_count),
    .stat_nan_count (stat_nan_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   c;
  } beat_t;

  beat_t exp_q[$];
  bit    rand_ready = 1'b0;

  function automatic void model_lane(input logic [31:0] x, output logic [31:0] d,
                                     output logic [1:0] c);
    d = x;
    c = 2'd0;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) c = 2'd3;
    else if (x[30:23] == 8'd0) d = 32'd0;
    else if (!x[31] && x > HI) begin d = HI; c = 2'd1; end
    else if (x[31] && x > LO) begin d = LO; c = 2'd2; end
  endfunction

  function automatic beat_t model_beat(input logic [127:0] x);
    beat_t       b;
    logic [31:0] ld;
    logic [1:0]  lc;
    for (int i = 0; i < LANES; i++) begin
      model_lane(x[32*i +: 32], ld, lc);
      b.d[32*i +: 32] = ld;
      b.c[2*i +: 2]   = lc;
    end
    return b;
  endfunction

  // Output monitor: scoreboard pop, stall stability and s_ready recovery.
  logic         prev_stall = 1'b0;
  logic         prev_s_ready = 1'b0;
  logic         prev_m_ready = 1'b0;
  logic         prev_rst = 1'b1;
  logic [127:0] held_d = '0;
  logic [7:0]   held_c = '0;
  beat_t        mon_e;

  always @(negedge clk) begin
    if (!reset && prev_stall) begin
      check("stall_valid", 128'(m_valid), 128'(1));
      check("stall_data", m_data, held_d);
      check("stall_class", 128'(m_class), 128'(held_c));
    end
    if (!reset && !prev_rst && !prev_s_ready && prev_m_ready)
      check("s_ready_recover", 128'(s_ready), 128'(1));
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(m_valid), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", m_data, mon_e.d);
        check("out_class", 128'(m_class), 128'(mon_e.c));
      end
    end
    prev_stall   = !reset && m_valid && !m_ready;
    held_d       = m_data;
    held_c       = m_class;
    prev_s_ready = s_ready;
    prev_m_ready = m_ready;
    prev_rst     = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [127:0] d, input beat_t e);
    bit got = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = s_ready;
      tick();
    end
    if (got) exp_q.push_back(e);
    else check("accept_timeout", 128'(s_ready), 128'(1));
  endtask

  function automatic logic [31:0] rand_lane();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = SPECIALS[$urandom_range(0, 11)];
      2:       v = HI + 32'($urandom_range(0, 4)) - 32'd2;
      default: v = LO + 32'($urandom_range(0, 4)) - 32'd2;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    beat_t        e;

    repeat (3) tick();
    @(negedge clk);
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_m_data", m_data, 128'(0));
    check("rst_m_class", 128'(m_class), 128'(0));
    check("rst_ovf", 128'(stat_ovf_count), 128'(0));
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rst_s_ready_rise", 128'(s_ready), 128'(1));
    tick();

    // Directed lanes; expected values are written out by hand.
    m_ready = 1'b1;
    e.d = {32'h7FC00001, LO, HI, 32'h3F800000};
    e.c = 8'hE4;
    send({32'h7FC00001, 32'hC3000000, 32'h43000000, 32'h3F800000}, e);
    s_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", 128'(m_valid), 128'(1));
    check("t1_data", m_data, {32'h7FC00001, 32'hC2CFF1B5, 32'h42B17218, 32'h3F800000});
    check("t1_class", 128'(m_class), 128'(8'hE4));
    tick();

    e.d = {LO, HI, 32'h0, 32'h0};
    e.c = 8'h00;
    send({32'hC2CFF1B5, 32'h42B17218, 32'h80000000, 32'h00000001}, e);
    e.d = {LO, HI, LO, HI};
    e.c = 8'h99;
    send({32'hC2CFF1B6, 32'h42B17219, 32'hFF800000, 32'h7F800000}, e);
    e.d = {32'h42B17217, 32'hC2CFF1B4, 32'h00000000, 32'hFF800001};
    e.c = 8'h03;
    send({32'h42B17217, 32'hC2CFF1B4, 32'h807FFFFF, 32'hFF800001}, e);
    s_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back random traffic under random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int l = 0; l < LANES; l++) d[32*l +: 32] = rand_lane();
      send(d, model_beat(d));
    end
    s_valid    = 1'b0;
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 128'(exp_q.size()), 128'(0));

`ifndef EXP_F32_PRECLAMP_STATS_EN
    @(negedge clk);
    check("stats_off_ovf", 128'(stat_ovf_count), 128'(0));
    check("stats_off_udf", 128'(stat_udf_count), 128'(0));
    check("stats_off_nan", 128'(stat_nan_count), 128'(0));
    tick();
`endif

    // Fill both slice entries, then reset: everything in flight is dropped.
    m_ready = 1'b0;
    e.d = {4{32'h3F800000}};
    e.c = 8'h00;
    send({4{32'h3F800000}}, e);
    send({4{32'h3F800000}}, e);
    s_valid = 1'b0;
    @(negedge clk);
    check("full_m_valid", 128'(m_valid), 128'(1));
    check("full_s_ready", 128'(s_ready), 128'(0));
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_m_valid", 128'(m_valid), 128'(0));
    check("midrst_s_ready", 128'(s_ready), 128'(0));
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("postrst_s_ready", 128'(s_ready), 128'(1));
    check("postrst_m_valid", 128'(m_valid), 128'(0));
    tick();
    m_ready = 1'b1;
    repeat (5) tick();

`ifdef EXP_F32_PRECLAMP_STATS_EN
    e.d = {4{HI}};
    e.c = 8'h55;
    repeat (10) send({4{PINF}}, e);
    s_valid = 1'b0;
    @(negedge clk);
    check("stat_ovf_40", 128'(stat_ovf_count), 128'(40));
    check("stat_udf_0", 128'(stat_udf_count), 128'(0));
    check("stat_nan_0", 128'(stat_nan_count), 128'(0));
    tick();
    stat_clear = 1'b1;
    send({4{PINF}}, e);
    stat_clear = 1'b0;
    s_valid    = 1'b0;
    @(negedge clk);
    check("stat_clear_wins", 128'(stat_ovf_count), 128'(0));
    tick();
    repeat (63) send({4{PINF}}, e);
    e.d = {32'h3F800000, 32'h3F800000, HI, HI};
    e.c = 8'h05;
    send({32'h3F800000, 32'h3F800000, PINF, PINF}, e);
    s_valid = 1'b0;
    @(negedge clk);
    check("stat_ovf_254", 128'(stat_ovf_count), 128'(254));
    tick();
    e.d = {4{HI}};
    e.c = 8'h55;
    send({4{PINF}}, e);
    e.d = {4{LO}};
    e.c = 8'hAA;
    send({4{32'hFF800000}}, e);
    e.d = {4{32'h7FC00000}};
    e.c = 8'hFF;
    send({4{32'h7FC00000}}, e);
    s_valid = 1'b0;
    @(negedge clk);
    check("stat_ovf_sat", 128'(stat_ovf_count), 128'(255));
    check("stat_udf_4", 128'(stat_udf_count), 128'(4));
    check("stat_nan_4", 128'(stat_nan_count), 128'(4));
    tick();
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("final_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
